// File: rtl/alu_core.sv
// Eight-operation MIPS-funct ALU: combinational compute stage, then one register
// stage holding result, carry/borrow and zero flag for the LED bank.
module alu_core #(
  parameter int NB_DATA = 4,
  parameter int NB_OP   = 6
) (
  input  logic               clk,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_datoA,
  input  logic [NB_DATA-1:0] i_datoB,
  input  logic [NB_OP-1:0]   i_operation,
  output logic [NB_DATA-1:0] o_leds,
  output logic               o_carry,
  output logic               o_zero
);

  localparam logic [NB_OP-1:0] OP_ADD = NB_OP'(6'b100000);
  localparam logic [NB_OP-1:0] OP_SUB = NB_OP'(6'b100010);
  localparam logic [NB_OP-1:0] OP_AND = NB_OP'(6'b100100);
  localparam logic [NB_OP-1:0] OP_OR  = NB_OP'(6'b100101);
  localparam logic [NB_OP-1:0] OP_XOR = NB_OP'(6'b100110);
  localparam logic [NB_OP-1:0] OP_NOR = NB_OP'(6'b100111);
  localparam logic [NB_OP-1:0] OP_SRA = NB_OP'(6'b000011);
  localparam logic [NB_OP-1:0] OP_SRL = NB_OP'(6'b000010);

  // Shift amounts at or beyond the operand width saturate to full sign/zero fill.
  localparam logic [NB_DATA:0] SHIFT_LIM = (NB_DATA + 1)'(NB_DATA);

  function automatic logic [NB_DATA-1:0] shift_ra(input logic [NB_DATA-1:0] a,
                                                  input logic [NB_DATA-1:0] b);
    logic signed [NB_DATA-1:0] sa;
    sa = a;
    if ({1'b0, b} >= SHIFT_LIM) return {NB_DATA{a[NB_DATA-1]}};
    return sa >>> b;
  endfunction

  function automatic logic [NB_DATA-1:0] shift_rl(input logic [NB_DATA-1:0] a,
                                                  input logic [NB_DATA-1:0] b);
    if ({1'b0, b} >= SHIFT_LIM) return '0;
    return a >> b;
  endfunction

  logic signed [NB_DATA:0]   sum_p0;
  logic signed [NB_DATA:0]   diff_p0;
  logic        [NB_DATA-1:0] result_p0;
  logic                      carry_p0;
  logic                      zero_p0;

  logic        [NB_DATA-1:0] result_p1;
  logic                      carry_p1;
  logic                      zero_p1;

  // Stage p0: operand decode and compute
  always_comb begin
    sum_p0    = $signed({1'b0, i_datoA} + {1'b0, i_datoB});
    diff_p0   = $signed({1'b0, i_datoA} - {1'b0, i_datoB});
    result_p0 = '0;
    carry_p0  = 1'b0;
    case (i_operation)
      OP_ADD: begin
        result_p0 = sum_p0[NB_DATA-1:0];
        carry_p0  = sum_p0[NB_DATA];
      end
      OP_SUB: begin
        result_p0 = diff_p0[NB_DATA-1:0];
        carry_p0  = diff_p0[NB_DATA];
      end
      OP_AND:  result_p0 = i_datoA & i_datoB;
      OP_OR:   result_p0 = i_datoA | i_datoB;
      OP_XOR:  result_p0 = i_datoA ^ i_datoB;
      OP_NOR:  result_p0 = ~(i_datoA | i_datoB);
      OP_SRA:  result_p0 = shift_ra(i_datoA, i_datoB);
      OP_SRL:  result_p0 = shift_rl(i_datoA, i_datoB);
      default: begin
        result_p0 = '0;
        carry_p0  = 1'b0;
      end
    endcase
    zero_p0 = (result_p0 == '0);
  end

  // Stage p1: registered outputs; reset forces the idle "zero" state
  always_ff @(posedge clk) begin
    if (i_reset) begin
      result_p1 <= '0;
      carry_p1  <= 1'b0;
      zero_p1   <= 1'b1;
    end else begin
      result_p1 <= result_p0;
      carry_p1  <= carry_p0;
      zero_p1   <= zero_p0;
    end
  end

  assign o_leds  = result_p1;
  assign o_carry = carry_p1;
  assign o_zero  = zero_p1;

endmodule

// File: tb/tb_alu_core.sv
// Directed-vector bench for alu_core: hand-computed results, flags and one-cycle latency.
module tb_alu_core;

  localparam int NB_DATA = 4;
  localparam int NB_OP   = 6;

  localparam logic [5:0] ADD = 6'b100000;
  localparam logic [5:0] SUB = 6'b100010;
  localparam logic [5:0] AND = 6'b100100;
  localparam logic [5:0] OR  = 6'b100101;
  localparam logic [5:0] XOR = 6'b100110;
  localparam logic [5:0] NOR = 6'b100111;
  localparam logic [5:0] SRA = 6'b000011;
  localparam logic [5:0] SRL = 6'b000010;
  localparam logic [5:0] BAD = 6'b111111;

  logic               clk = 1'b0;
  logic               i_reset;
  logic [NB_DATA-1:0] i_datoA;
  logic [NB_DATA-1:0] i_datoB;
  logic [NB_OP-1:0]   i_operation;
  logic [NB_DATA-1:0] o_leds;
  logic               o_carry;
  logic               o_zero;

  int n_checks = 0;
  int n_fail   = 0;
  logic [5:0] prev_exp;

  alu_core #(.NB_DATA(NB_DATA), .NB_OP(NB_OP)) dut (
    .clk         (clk),
    .i_reset     (i_reset),
    .i_datoA     (i_datoA),
    .i_datoB     (i_datoB),
    .i_operation (i_operation),
    .o_leds      (o_leds),
    .o_carry     (o_carry),
    .o_zero      (o_zero)
  );

  always #5 clk = ~clk;

  // Packed as {leds[3:0], carry, zero}
  task automatic check(input string tag, input logic [5:0] got, input logic [5:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got leds=%b c=%b z=%b, expected leds=%b c=%b z=%b",
               tag, got[5:2], got[1], got[0], exp[5:2], exp[1], exp[0]);
    end
  endtask

  // Drive at negedge, confirm outputs still hold the previous result, then check after the edge.
  task automatic run(input string tag, input logic rst, input logic [5:0] op,
                     input logic [3:0] a, input logic [3:0] b,
                     input logic [3:0] leds, input logic c, input logic z);
    @(negedge clk);
    i_reset     = rst;
    i_operation = op;
    i_datoA     = a;
    i_datoB     = b;
    #2;
    check({tag, "_hold"}, {o_leds, o_carry, o_zero}, prev_exp);
    @(posedge clk);
    #1;
    check(tag, {o_leds, o_carry, o_zero}, {leds, c, z});
    prev_exp = {leds, c, z};
  endtask

  initial begin
    i_reset     = 1'b1;
    i_operation = ADD;
    i_datoA     = 4'hF;
    i_datoB     = 4'h1;
    repeat (2) @(posedge clk);
    #1;
    check("reset", {o_leds, o_carry, o_zero}, {4'b0000, 1'b0, 1'b1});
    prev_exp = {4'b0000, 1'b0, 1'b1};

    run("add_3_5",   1'b0, ADD, 4'b0011, 4'b0101, 4'b1000, 1'b0, 1'b0);
    run("add_f_1",   1'b0, ADD, 4'b1111, 4'b0001, 4'b0000, 1'b1, 1'b1);
    run("and_f_f",   1'b0, AND, 4'b1111, 4'b1111, 4'b1111, 1'b0, 1'b0);
    run("sub_6_3",   1'b0, SUB, 4'b0110, 4'b0011, 4'b0011, 1'b0, 1'b0);
    run("sub_3_5",   1'b0, SUB, 4'b0011, 4'b0101, 4'b1110, 1'b1, 1'b0);
    run("sub_5_5",   1'b0, SUB, 4'b0101, 4'b0101, 4'b0000, 1'b0, 1'b1);
    run("and_c_a",   1'b0, AND, 4'b1100, 4'b1010, 4'b1000, 1'b0, 1'b0);
    run("or_c_a",    1'b0, OR,  4'b1100, 4'b1010, 4'b1110, 1'b0, 1'b0);
    run("xor_c_a",   1'b0, XOR, 4'b1100, 4'b1010, 4'b0110, 1'b0, 1'b0);
    run("nor_c_a",   1'b0, NOR, 4'b1100, 4'b1010, 4'b0001, 1'b0, 1'b0);
    run("xor_a_a",   1'b0, XOR, 4'b1010, 4'b1010, 4'b0000, 1'b0, 1'b1);
    run("sra_c_2",   1'b0, SRA, 4'b1100, 4'b0010, 4'b1111, 1'b0, 1'b0);
    run("sra_4_1",   1'b0, SRA, 4'b0100, 4'b0001, 4'b0010, 1'b0, 1'b0);
    run("sra_8_7",   1'b0, SRA, 4'b1000, 4'b0111, 4'b1111, 1'b0, 1'b0);
    run("sra_7_4",   1'b0, SRA, 4'b0111, 4'b0100, 4'b0000, 1'b0, 1'b1);
    run("srl_c_1",   1'b0, SRL, 4'b1100, 4'b0001, 4'b0110, 1'b0, 1'b0);
    run("srl_c_4",   1'b0, SRL, 4'b1100, 4'b0100, 4'b0000, 1'b0, 1'b1);
    run("srl_8_3",   1'b0, SRL, 4'b1000, 4'b0011, 4'b0001, 1'b0, 1'b0);
    run("bad_op",    1'b0, BAD, 4'b1111, 4'b0001, 4'b0000, 1'b0, 1'b1);
    run("add_7_2",   1'b0, ADD, 4'b0111, 4'b0010, 4'b1001, 1'b0, 1'b0);
    run("rst_mid",   1'b1, ADD, 4'b1111, 4'b0001, 4'b0000, 1'b0, 1'b1);
    run("after_rst", 1'b0, OR,  4'b0001, 4'b0100, 4'b0101, 1'b0, 1'b0);
    run("b2b_add",   1'b0, ADD, 4'b1001, 4'b1001, 4'b0010, 1'b1, 1'b0);
    run("b2b_nor",   1'b0, NOR, 4'b0000, 4'b0000, 4'b1111, 1'b0, 1'b0);
    run("b2b_sub",   1'b0, SUB, 4'b0000, 4'b0001, 4'b1111, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
